// File: rtl/ws2812_pkg.sv
// WS2812 encoder shared types, default timing for the 65 MHz build, and
// elaboration helpers (counter sizing, timing sanity check).
// No ports; imported by ws2812_bit_timer and ws2812_stream_tx.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    // 65 MHz build: 1.2 us bit, 0.29 us / 0.6 us highs, 80 us latch gap
    localparam int DEF_BITS      = 24;
    localparam int DEF_T_BIT     = 78;
    localparam int DEF_T0H       = 19;
    localparam int DEF_T1H       = 39;
    localparam int DEF_LATCH_CYC = 5200;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A '0' must be visibly shorter than a '1', and a '1' must leave a low tail.
    function automatic bit timing_ok(input int bits, input int t_bit,
                                     input int t0h, input int t1h);
        return (bits >= 1) && (t0h < t1h) && (t1h < t_bit);
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Bit/latch cycle counter with terminal flags and the registered dout comparator.
// Latency: dout is registered, one cycle behind cnt. No backpressure; follows FSM state.
// Ports: clk, inter_rst (async, active-low), state/bit_val in; cnt_end, latch_end, dout out.
module ws2812_bit_timer
    import ws2812_pkg::*;
#(
    parameter int T_BIT     = DEF_T_BIT,
    parameter int T0H       = DEF_T0H,
    parameter int T1H       = DEF_T1H,
    parameter int LATCH_CYC = DEF_LATCH_CYC,
    parameter int CW        = 13
) (
    input  logic   clk,
    input  logic   inter_rst,
    input  state_t state,
    input  logic   bit_val,
    output logic   cnt_end,
    output logic   latch_end,
    output logic   dout
);

    localparam logic [CW-1:0] BIT_LAST   = CW'(T_BIT - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYC - 1);
    localparam logic [CW-1:0] T0H_C      = CW'(T0H);
    localparam logic [CW-1:0] T1H_C      = CW'(T1H);

    logic [CW-1:0] cnt;

    assign cnt_end   = (state == SEND)  && (cnt == BIT_LAST);
    assign latch_end = (state == LATCH) && (cnt == LATCH_LAST);

    // Every state exit coincides with a terminal count, so the wrap to zero
    // also serves as the start of the next bit, pixel or latch gap.
    always_ff @(posedge clk or negedge inter_rst) begin
        if (!inter_rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            case (state)
                SEND:    cnt <= cnt_end   ? '0 : cnt + CW'(1);
                LATCH:   cnt <= latch_end ? '0 : cnt + CW'(1);
                default: cnt <= '0;
            endcase
            dout <= (state == SEND) && (cnt < (bit_val ? T1H_C : T0H_C));
        end
    end

endmodule

// File: rtl/ws2812_stream_tx.sv
// WS2812 serial encoder: GRB words over valid/ready -> single-wire NRZ, MSB first, with latch gap.
// Latency: accept at edge k -> SEND at k+1 -> dout rises after k+2; chained pixels have zero gap.
// Backpressure: s_ready = hold buffer empty and not in LATCH; a word offered during the gap waits.
// Ports: clk, inter_rst (async, active-low); s_valid/s_ready/s_data/s_last stream in;
//        dout (registered line), busy, frame_done and underrun (1-cycle pulses) out.
module ws2812_stream_tx
    import ws2812_pkg::*;
#(
    parameter int BITS      = DEF_BITS,
    parameter int T_BIT     = DEF_T_BIT,
    parameter int T0H       = DEF_T0H,
    parameter int T1H       = DEF_T1H,
    parameter int LATCH_CYC = DEF_LATCH_CYC
) (
    input  logic            clk,
    input  logic            inter_rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [BITS-1:0] s_data,
    input  logic            s_last,
    output logic            dout,
    output logic            busy,
    output logic            frame_done,
    output logic            underrun
);

    localparam int CW = $clog2(max_int(T_BIT, LATCH_CYC));
    localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(BITS - 1);

    generate
        if (!timing_ok(BITS, T_BIT, T0H, T1H)) begin : g_bad_timing
            $error("ws2812_stream_tx: need BITS>=1 and T0H < T1H < T_BIT");
        end
    endgenerate

    state_t            state, state_nxt;
    logic [BITS-1:0]   hold_dat, shift;
    logic              hold_last, hold_full, shift_last;
    logic [IW-1:0]     bit_idx;
    logic              ready_en;
    logic              load_shift, ur_nxt, fd_nxt;
    logic              cnt_end, latch_end, pixel_end, accept;

    ws2812_bit_timer #(
        .T_BIT     (T_BIT),
        .T0H       (T0H),
        .T1H       (T1H),
        .LATCH_CYC (LATCH_CYC),
        .CW        (CW)
    ) u_timer (
        .clk       (clk),
        .inter_rst (inter_rst),
        .state     (state),
        .bit_val   (shift[BITS-1]),
        .cnt_end   (cnt_end),
        .latch_end (latch_end),
        .dout      (dout)
    );

    // ready_en keeps s_ready low until the first edge after reset release.
    assign s_ready   = ready_en && !hold_full && (state != LATCH);
    assign accept    = s_valid && s_ready;
    assign busy      = (state != IDLE) || hold_full;
    assign pixel_end = cnt_end && (bit_idx == '0);

    always_comb begin
        state_nxt  = state;
        load_shift = 1'b0;
        ur_nxt     = 1'b0;
        fd_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    state_nxt  = SEND;
                    load_shift = 1'b1;
                end
            end
            SEND: begin
                if (pixel_end) begin
                    if (shift_last) begin
                        state_nxt = LATCH;
                    end else if (hold_full) begin
                        load_shift = 1'b1;
                    end else begin
                        state_nxt = LATCH;
                        ur_nxt    = 1'b1;
                    end
                end
            end
            LATCH: begin
                if (latch_end) begin
                    state_nxt = IDLE;
                    fd_nxt    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge inter_rst) begin
        if (!inter_rst) begin
            state      <= IDLE;
            ready_en   <= 1'b0;
            hold_dat   <= '0;
            hold_last  <= 1'b0;
            hold_full  <= 1'b0;
            shift      <= '0;
            shift_last <= 1'b0;
            bit_idx    <= '0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nxt;
            ready_en   <= 1'b1;
            frame_done <= fd_nxt;
            underrun   <= ur_nxt;
            // A word arriving on the edge that drains the hold register wins,
            // so nothing is lost when accept and reload coincide.
            if (accept) begin
                hold_dat  <= s_data;
                hold_last <= s_last;
                hold_full <= 1'b1;
            end else if (load_shift) begin
                hold_full <= 1'b0;
            end
            if (load_shift) begin
                shift      <= hold_dat;
                shift_last <= hold_last;
                bit_idx    <= IDX_TOP;
            end else if (cnt_end) begin
                shift <= shift << 1;
                if (bit_idx != '0) begin
                    bit_idx <= bit_idx - IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ws2812_stream_tx.sv
// Scoreboard bench: stimulus pushes per-bit expected high times; a negedge monitor
// measures dout highs, rise-to-rise periods, underrun/frame_done positions.
// Channel 0: default 24-bit build. Channel 1: 32-bit, T_BIT=60, T0H=15, T1H=30.
module tb_ws2812_stream_tx;

    localparam int LATCH = 5200;

    typedef struct {
        int high;
        int kind;   // 0: next bit follows contiguously, 1: frame end, 2: underrun end
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, s_valid_a, s_ready_a, s_last_a, dout_a, busy_a, fd_a, ur_a;
    logic [23:0] s_data_a;
    logic        rst_b, s_valid_b, s_ready_b, s_last_b, dout_b, busy_b, fd_b, ur_b;
    logic [31:0] s_data_b;

    ws2812_stream_tx dut_a (
        .clk(clk), .inter_rst(rst_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
        .s_data(s_data_a), .s_last(s_last_a), .dout(dout_a), .busy(busy_a),
        .frame_done(fd_a), .underrun(ur_a)
    );

    ws2812_stream_tx #(.BITS(32), .T_BIT(60), .T0H(15), .T1H(30), .LATCH_CYC(LATCH)) dut_b (
        .clk(clk), .inter_rst(rst_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .s_data(s_data_b), .s_last(s_last_b), .dout(dout_b), .busy(busy_b),
        .frame_done(fd_b), .underrun(ur_b)
    );

    int tbit[2] = '{78, 60};
    int t0h[2]  = '{19, 15};
    int t1h[2]  = '{39, 30};
    int nbits[2] = '{24, 32};

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q0[$];
    exp_t q1[$];
    bit   mon_en[2];
    logic prev[2];
    int   hcnt[2];
    int   rise_cyc[2];
    bit   have[2];
    exp_t cur[2];
    bit   exp_fd[2];
    bit   exp_ur[2];
    int   cyc = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mon_step(input int d, input logic dv, input logic fd, input logic ur);
        exp_t e;
        bit   got;
        if (!mon_en[d]) begin
            prev[d]   = dv;
            have[d]   = 1'b0;
            exp_fd[d] = 1'b0;
            exp_ur[d] = 1'b0;
            return;
        end
        if (dv && !prev[d]) begin
            if (have[d] && cur[d].kind == 0)
                check($sformatf("ch%0d bit period", d), cyc - rise_cyc[d], tbit[d]);
            got = 1'b0;
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            check($sformatf("ch%0d expected bit present", d), got, 1);
            have[d] = got;
            if (got) cur[d] = e;
            rise_cyc[d] = cyc;
            hcnt[d] = 1;
        end else if (dv) begin
            hcnt[d]++;
        end else if (prev[d] && have[d]) begin
            check($sformatf("ch%0d high time", d), hcnt[d], cur[d].high);
            if (cur[d].kind != 0) begin
                exp_fd[d] = 1'b1;
                exp_ur[d] = (cur[d].kind == 2);
            end
        end
        if (ur) begin
            check($sformatf("ch%0d underrun expected", d), exp_ur[d], 1);
            if (exp_ur[d])
                check($sformatf("ch%0d underrun position", d), cyc - rise_cyc[d], tbit[d] - 1);
            exp_ur[d] = 1'b0;
        end
        if (fd) begin
            check($sformatf("ch%0d frame_done expected", d), exp_fd[d], 1);
            if (exp_fd[d])
                check($sformatf("ch%0d frame_done position", d), cyc - rise_cyc[d],
                      tbit[d] + LATCH - 1);
            exp_fd[d] = 1'b0;
        end
        prev[d] = dv;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            mon_step(0, dout_a, fd_a, ur_a);
            mon_step(1, dout_b, fd_b, ur_b);
        end
    end

    task automatic push_word(input int d, input logic [31:0] data, input int kind);
        for (int i = nbits[d] - 1; i >= 0; i--) begin
            exp_t e;
            e.high = data[i] ? t1h[d] : t0h[d];
            e.kind = (i == 0) ? kind : 0;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [31:0] data, input logic last);
        if (d == 0) begin s_valid_a = v; s_data_a = data[23:0]; s_last_a = last; end
        else        begin s_valid_b = v; s_data_b = data;       s_last_b = last; end
    endtask

    // Offers a word at a negedge and returns just after the accepting edge.
    task automatic send(input int d, input logic [31:0] data, input logic last, input int kind);
        push_word(d, data, kind);
        @(negedge clk);
        drive(d, 1'b1, data, last);
        for (int w = 0; w < 20000; w++) begin
            if ((d == 0) ? s_ready_a : s_ready_b) begin
                @(posedge clk);
                return;
            end
            @(negedge clk);
        end
        check($sformatf("ch%0d send accepted", d), 0, 1);
    endtask

    task automatic release_bus(input int d);
        @(negedge clk);
        drive(d, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic wait_fd(input int d);
        for (int w = 0; w < 20000; w++) begin
            @(negedge clk);
            if ((d == 0) ? fd_a : fd_b) return;
        end
        check($sformatf("ch%0d frame_done within budget", d), 0, 1);
    endtask

    task automatic frame_checks(input int d, input string tag);
        check({tag, " busy at frame_done"}, (d == 0) ? busy_a : busy_b, 0);
        @(negedge clk);
        check({tag, " queue drained"}, (d == 0) ? q0.size() : q1.size(), 0);
        check({tag, " frame_done seen"}, exp_fd[d], 0);
        check({tag, " underrun seen"}, exp_ur[d], 0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rises;
        bit  pd;
        bit  got;
        mon_en = '{1'b0, 1'b0};
        rst_a = 1'b1; rst_b = 1'b1;
        drive(0, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 1'b0);
        #3;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst dout", dout_a, 0);
        check("rst s_ready", s_ready_a, 0);
        check("rst busy", busy_a, 0);
        check("rst frame_done", fd_a, 0);
        check("rst underrun", ur_a, 0);
        check("rst ch1 dout", dout_b, 0);
        rst_a = 1'b1; rst_b = 1'b1;
        #1;
        check("s_ready before first edge", s_ready_a, 0);
        @(negedge clk);
        check("s_ready after first edge", s_ready_a, 1);
        check("ch1 s_ready after first edge", s_ready_b, 1);
        mon_en = '{1'b1, 1'b1};

        // 1: single pixel 0xFF0000, last
        send(0, 32'h00FF0000, 1'b1, 1);
        release_bus(0);
        wait_fd(0);
        frame_checks(0, "t1");

        // 2: three chained words, valid held high, last on the third
        send(0, 32'h00A5A5A5, 1'b0, 0);
        send(0, 32'h00000001, 1'b0, 0);
        send(0, 32'h00FFFFFF, 1'b1, 1);
        release_bus(0);
        wait_fd(0);
        frame_checks(0, "t2");

        // 3: lone word without last -> underrun then latch
        send(0, 32'h000F00F0, 1'b0, 2);
        release_bus(0);
        wait_fd(0);
        frame_checks(0, "t3");

        // 4: reset in the middle of bit 5 (cnt 10), then clean restart
        mon_en[0] = 1'b0;
        send(0, 32'h00FFFFFF, 1'b1, 1);
        release_bus(0);
        rises = 0;
        pd = 1'b0;
        for (int w = 0; w < 2000 && rises < 6; w++) begin
            @(negedge clk);
            if (dout_a && !pd) rises++;
            pd = dout_a;
        end
        check("t4 six rises", rises, 6);
        repeat (9) @(negedge clk);
        check("t4 dout high before reset", dout_a, 1);
        rst_a = 1'b0;
        #1;
        check("t4 dout low on async reset", dout_a, 0);
        check("t4 s_ready in reset", s_ready_a, 0);
        check("t4 busy in reset", busy_a, 0);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("t4 s_ready before edge", s_ready_a, 0);
        @(negedge clk);
        check("t4 s_ready after edge", s_ready_a, 1);
        check("t4 busy after reset", busy_a, 0);
        q0.delete();
        mon_en[0] = 1'b1;
        send(0, 32'h00800000, 1'b1, 1);
        release_bus(0);
        wait_fd(0);
        frame_checks(0, "t4");

        // 5: word offered during LATCH waits for the first IDLE cycle
        send(0, 32'h0000FF00, 1'b1, 1);
        release_bus(0);
        repeat (3) @(negedge clk);
        got = 1'b0;
        for (int w = 0; w < 3000; w++) begin
            if (!s_ready_a) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("t5 reached latch", got, 1);
        push_word(0, 32'h00800000, 1);
        drive(0, 1'b1, 32'h00800000, 1'b1);
        got = 1'b0;
        for (int w = 0; w < 6000; w++) begin
            if (s_ready_a) begin
                check("t5 ready only in first idle cycle", fd_a, 1);
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t5 accepted", got, 1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 1'b0);
        check("t5 dout k", dout_a, 0);
        @(negedge clk);
        check("t5 dout k+1", dout_a, 0);
        @(negedge clk);
        check("t5 dout k+2", dout_a, 1);
        wait_fd(0);
        frame_checks(0, "t5");

        // 6: 32-bit build, 60-cycle bits, 15/30 highs
        send(1, 32'hFF000000, 1'b1, 1);
        release_bus(1);
        wait_fd(1);
        frame_checks(1, "t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
